// File: rtl/wave_pkg.sv
// wave_pkg: shared waveform indices, default widths and sample/state types
package wave_pkg;
  localparam int WAVE_NOISE = 0;
  localparam int WAVE_TRI = 1;
  localparam int WAVE_SAW = 2;
  localparam int WAVE_SQUARE = 3;
  localparam int WAVE_SINE = 4;
  localparam int WAVE_DATA_W = 16;
  localparam int WAVE_N = 5;
  localparam int WAVE_SEL_W = 3;
  typedef logic signed [WAVE_DATA_W-1:0] sample_t;
  typedef enum logic {IDLE, FADE} xfade_state_t;
endpackage

// File: rtl/wave_xfade_mix.sv
// wave_xfade_mix: floor((a*(L-k) + b*k) / L) with L = 2^XFADE_LOG2
module wave_xfade_mix #(
  parameter int DATA_W = 16,
  parameter int XFADE_LOG2 = 6,
  localparam int KW = XFADE_LOG2 > 0 ? XFADE_LOG2 : 1
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic        [KW-1:0]     k,
  output logic        [DATA_W-1:0] mixed
);
  localparam int L = 1 << XFADE_LOG2;
  localparam int WW = XFADE_LOG2 + 2;
  localparam int PW = DATA_W + XFADE_LOG2 + 1;
  logic signed [WW-1:0] wa, wb;
  logic signed [PW-1:0] pa, pb;
  logic signed [PW:0] sum;
  // weights are non-negative and sum to L, so the result never leaves the input range
  always_comb begin
    wa = WW'(L) - WW'(k);
    wb = WW'(k);
    pa = PW'(a) * PW'(wa);
    pb = PW'(b) * PW'(wb);
    sum = (PW+1)'(pa) + (PW+1)'(pb);
    mixed = DATA_W'(sum >>> XFADE_LOG2);
  end
endmodule

// File: rtl/wave_xfade_mux.sv
// wave_xfade_mux: strobed waveform selector with a linear crossfade on selection change
module wave_xfade_mux
  import wave_pkg::*;
#(
  parameter int DATA_W = WAVE_DATA_W,
  parameter int N_WAVES = WAVE_N,
  parameter int SEL_W = WAVE_SEL_W,
  parameter int XFADE_LOG2 = 6,
  parameter int RST_SEL = WAVE_SINE
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_sample_en,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [N_WAVES*DATA_W-1:0] i_waves,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_valid,
  output logic                      o_busy
);
  localparam int KW = XFADE_LOG2 > 0 ? XFADE_LOG2 : 1;
  localparam logic [KW-1:0] K_LAST = KW'((1 << XFADE_LOG2) - 1);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_WAVES - 1);
  localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(RST_SEL);
  xfade_state_t state_q, state_d;
  logic [SEL_W-1:0] cur_q, cur_d, nxt_q, nxt_d, sel_m;
  logic [KW-1:0] k_q, k_d;
  logic signed [DATA_W-1:0] waves [N_WAVES];
  logic [DATA_W-1:0] mixed;
  for (genvar w = 0; w < N_WAVES; w++) begin : g_unpack
    assign waves[w] = i_waves[w*DATA_W +: DATA_W];
  end
  assign sel_m = i_sel > SEL_MAX ? SEL_MAX : i_sel;
  assign o_busy = state_q == FADE;
  // in IDLE k is 0, so the mixer passes the current waveform through unchanged
  wave_xfade_mix #(.DATA_W(DATA_W), .XFADE_LOG2(XFADE_LOG2)) u_mix (
    .a(waves[cur_q]),
    .b(waves[nxt_q]),
    .k(k_q),
    .mixed(mixed)
  );
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    nxt_d = nxt_q;
    k_d = k_q;
    if (i_sample_en) begin
      if (state_q == FADE) begin
        if (k_q == K_LAST) begin
          cur_d = nxt_q;
          k_d = '0;
          state_d = IDLE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end else if (sel_m != cur_q) begin
        if (XFADE_LOG2 == 0) begin
          cur_d = sel_m;
        end else begin
          nxt_d = sel_m;
          k_d = '0;
          state_d = FADE;
        end
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cur_q <= SEL_RST;
      nxt_q <= SEL_RST;
      k_q <= '0;
      o_data <= '0;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      nxt_q <= nxt_d;
      k_q <= k_d;
      o_valid <= i_sample_en;
      if (i_sample_en) o_data <= mixed;
    end
  end
endmodule

// File: tb/tb_wave_xfade_mux.sv
// tb_wave_xfade_mux: checks a 64-sample-fade build and an instant-switch build against a reference model
module tb_wave_xfade_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_en = 1'b0;
  logic [2:0] sel = 3'd4;
  logic [79:0] waves = '0;
  logic [15:0] d0, d1;
  logic v0, v1, b0, b1;
  int total = 0;
  int bad = 0;
  int lg [2] = '{6, 0};
  int m_cur [2], m_nxt [2], m_k [2];
  logic [15:0] ed [2];
  logic last_en = 1'b0;

  typedef struct {
    int s;
    logic [15:0] d;
    logic b;
  } vec_t;
  vec_t tbl [8];
  logic [15:0] rec_d [66];
  logic rec_b [66];

  always #5 clk = ~clk;

  wave_xfade_mux #(.XFADE_LOG2(6)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_en(sample_en), .i_sel(sel),
    .i_waves(waves), .o_data(d0), .o_valid(v0), .o_busy(b0)
  );
  wave_xfade_mux #(.XFADE_LOG2(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_en(sample_en), .i_sel(sel),
    .i_waves(waves), .o_data(d1), .o_valid(v1), .o_busy(b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wv(input int w);
    logic [15:0] v;
    v = waves[w*16 +: 16];
    return int'($signed(v));
  endfunction

  // floor((a*(L-k) + b*k) / L) done with ordinary integer division
  function automatic logic [15:0] mixf(input int a, input int b, input int k, input int l);
    longint s, q;
    s = longint'(a) * (l - k) + longint'(b) * k;
    q = s / l;
    if (s % l != 0 && s < 0) q = q - 1;
    return q[15:0];
  endfunction

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      m_cur[m] = 4;
      m_nxt[m] = 4;
      m_k[m] = -1;
      ed[m] = 16'h0000;
    end
  endtask

  task automatic mstep(input int s);
    int ms, l;
    ms = s > 4 ? 4 : s;
    for (int m = 0; m < 2; m++) begin
      l = 1 << lg[m];
      if (m_k[m] >= 0) begin
        ed[m] = mixf(wv(m_cur[m]), wv(m_nxt[m]), m_k[m], l);
        m_k[m]++;
        if (m_k[m] == l) begin
          m_cur[m] = m_nxt[m];
          m_k[m] = -1;
        end
      end else begin
        ed[m] = 16'(wv(m_cur[m]));
        if (ms != m_cur[m]) begin
          if (l == 1) m_cur[m] = ms;
          else begin
            m_nxt[m] = ms;
            m_k[m] = 0;
          end
        end
      end
    end
  endtask

  task automatic cmp();
    chk("data0", 32'(d0), 32'(ed[0]));
    chk("valid0", 32'(v0), 32'(last_en));
    chk("busy0", 32'(b0), 32'(m_k[0] >= 0));
    chk("data1", 32'(d1), 32'(ed[1]));
    chk("valid1", 32'(v1), 32'(last_en));
    chk("busy1", 32'(b1), 32'(m_k[1] >= 0));
  endtask

  task automatic step(input logic en, input logic [2:0] s);
    @(negedge clk);
    sample_en = en;
    sel = s;
    @(posedge clk);
    #1;
    last_en = en;
    if (en) mstep(int'(s));
    cmp();
    sample_en = 1'b0;
  endtask

  task automatic set_w(input int w, input logic [15:0] v);
    waves[w*16 +: 16] = v;
  endtask

  initial begin
    tbl[0] = '{0, 16'hC000, 1'b1};
    tbl[1] = '{1, 16'hC000, 1'b1};
    tbl[2] = '{17, 16'hE000, 1'b1};
    tbl[3] = '{33, 16'h0000, 1'b1};
    tbl[4] = '{49, 16'h2000, 1'b1};
    tbl[5] = '{63, 16'h3C00, 1'b1};
    tbl[6] = '{64, 16'h3E00, 1'b0};
    tbl[7] = '{65, 16'h4000, 1'b0};
    mreset();
    #12;
    chk("rst_data0", 32'(d0), 32'h0);
    chk("rst_valid0", 32'(v0), 32'h0);
    chk("rst_busy0", 32'(b0), 32'h0);
    chk("rst_data1", 32'(d1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    set_w(0, 16'h0101);
    set_w(1, 16'h0202);
    set_w(2, 16'h0303);
    set_w(3, 16'h0404);
    set_w(4, 16'h1234);
    step(1'b1, 3'd4);
    chk("first_sine", 32'(d0), 32'h1234);
    chk("first_valid", 32'(v0), 32'h1);
    step(1'b0, 3'd4);
    chk("valid_one_cycle", 32'(v0), 32'h0);
    chk("data_hold", 32'(d0), 32'h1234);

    // fade sine -> saw, 66 back-to-back strobes
    set_w(4, 16'hC000);
    set_w(2, 16'h4000);
    for (int i = 0; i < 66; i++) begin
      step(1'b1, 3'd2);
      rec_d[i] = d0;
      rec_b[i] = b0;
    end
    foreach (tbl[i]) begin
      chk($sformatf("fade_data_s%0d", tbl[i].s), 32'(rec_d[tbl[i].s]), 32'(tbl[i].d));
      chk($sformatf("fade_busy_s%0d", tbl[i].s), 32'(rec_b[tbl[i].s]), 32'(tbl[i].b));
    end

    // return to sine, then out-of-range select must not fade
    for (int i = 0; i < 70 && (m_k[0] >= 0 || m_cur[0] != 4); i++) step(1'b1, 3'd4);
    chk("back_to_sine", 32'(m_cur[0]), 32'd4);
    for (int i = 0; i < 4; i++) begin
      set_w(4, 16'(16'h0100 * (i + 3)));
      step(1'b1, 3'd7);
      chk("oor_busy", 32'(b0), 32'h0);
      chk("oor_data", 32'(d0), 32'(16'h0100 * (i + 3)));
    end

    // toggle select mid-fade: the fade to saw finishes unchanged
    set_w(4, 16'hC000);
    step(1'b1, 3'd2);
    for (int i = 0; i < 64; i++) step(1'b1, (i < 30 && i[0]) ? 3'd0 : 3'd2);
    chk("toggle_busy_end", 32'(b0), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd2);
      chk("toggle_saw", 32'(d0), 32'h4000);
      chk("toggle_no_refade", 32'(b0), 32'h0);
    end

    // async reset in the middle of a fade back to sine
    step(1'b1, 3'd4);
    for (int i = 0; i < 21; i++) step(1'b1, 3'd4);
    chk("pre_rst_busy", 32'(b0), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(d0), 32'h0);
    chk("arst_busy", 32'(b0), 32'h0);
    chk("arst_valid", 32'(v0), 32'h0);
    mreset();
    last_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd2);
    chk("post_rst_sine", 32'(d0), 32'hC000);
    for (int i = 0; i < 70 && m_k[0] >= 0; i++) step(1'b1, 3'd4);
    for (int i = 0; i < 70 && (m_k[0] >= 0 || m_cur[0] != 4); i++) step(1'b1, 3'd4);

    // instant-switch build: 4 -> 3
    set_w(3, 16'h7FFF);
    set_w(4, 16'h1111);
    step(1'b1, 3'd3);
    chk("x0_switch_old", 32'(d1), 32'h1111);
    step(1'b1, 3'd3);
    chk("x0_square", 32'(d1), 32'h7FFF);
    chk("x0_busy", 32'(b1), 32'h0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) set_w(int'($urandom_range(0, 4)), 16'($urandom));
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
